// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: captures the M-stage bundle every edge and presents it as W.
// Optional build macro MEM_WB_ZERO_DST_SQUASH_EN drops register writes that target $0.
module mem_wb_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEMTOREG_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite_M,
  input  logic [MEMTOREG_W-1:0] MemtoReg_M,
  input  logic [DATA_W-1:0]     PC_M,
  input  logic [DATA_W-1:0]     PC8_M,
  input  logic [DATA_W-1:0]     ALUresult_M,
  input  logic [DATA_W-1:0]     MemOutput_M,
  input  logic [REG_ADDR_W-1:0] Dst_M,
  output logic                  RegWrite_W,
  output logic [MEMTOREG_W-1:0] MemtoReg_W,
  output logic [DATA_W-1:0]     PC_W,
  output logic [DATA_W-1:0]     PC8_W,
  output logic [DATA_W-1:0]     ALUresult_W,
  output logic [REG_ADDR_W-1:0] Dst_W,
  output logic [DATA_W-1:0]     MemOutput_W
);

  logic                  r_regwrite;
  logic [MEMTOREG_W-1:0] r_memtoreg;
  logic [DATA_W-1:0]     r_pc;
  logic [DATA_W-1:0]     r_pc8;
  logic [DATA_W-1:0]     r_aluresult;
  logic [DATA_W-1:0]     r_memoutput;
  logic [REG_ADDR_W-1:0] r_dst;
  logic                  w_regwrite_next;

`ifdef MEM_WB_ZERO_DST_SQUASH_EN
  // A write to $0 is turned into a bubble here so forwarding never sees it.
  assign w_regwrite_next = RegWrite_M & (Dst_M != '0);
`else
  assign w_regwrite_next = RegWrite_M;
`endif

  // NOTE: non-blocking assignments keep every field sampled at the same edge,
  // so fields of consecutive bundles can never mix.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite  <= 1'b0;
      r_memtoreg  <= '0;
      r_pc        <= '0;
      r_pc8       <= '0;
      r_aluresult <= '0;
      r_memoutput <= '0;
      r_dst       <= '0;
    end else begin
      r_regwrite  <= w_regwrite_next;
      r_memtoreg  <= MemtoReg_M;
      r_pc        <= PC_M;
      r_pc8       <= PC8_M;
      r_aluresult <= ALUresult_M;
      r_memoutput <= MemOutput_M;
      r_dst       <= Dst_M;
    end
  end

  assign RegWrite_W  = r_regwrite;
  assign MemtoReg_W  = r_memtoreg;
  assign PC_W        = r_pc;
  assign PC8_W       = r_pc8;
  assign ALUresult_W = r_aluresult;
  assign Dst_W       = r_dst;
  assign MemOutput_W = r_memoutput;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench for mem_wb_pipe_reg: directed vector table, mid-cycle and
// random sequences checked against a one-edge-delay reference model.
module tb_mem_wb_pipe_reg;

  typedef struct packed {
    logic        rw;
    logic [3:0]  mtr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dst;
  } bundle_t;

  typedef struct {
    logic    rst;
    bundle_t in;
    bundle_t exp;
    string   name;
  } vec_t;

`ifdef MEM_WB_ZERO_DST_SQUASH_EN
  localparam bit SQUASH = 1'b1;
`else
  localparam bit SQUASH = 1'b0;
`endif

  logic    clk = 1'b0;
  logic    reset;
  bundle_t in_b;
  bundle_t out_b;
  int      n_cmp = 0;
  int      n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_reg dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite_M (in_b.rw),
    .MemtoReg_M (in_b.mtr),
    .PC_M       (in_b.pc),
    .PC8_M      (in_b.pc8),
    .ALUresult_M(in_b.alu),
    .MemOutput_M(in_b.mem),
    .Dst_M      (in_b.dst),
    .RegWrite_W (out_b.rw),
    .MemtoReg_W (out_b.mtr),
    .PC_W       (out_b.pc),
    .PC8_W      (out_b.pc8),
    .ALUresult_W(out_b.alu),
    .Dst_W      (out_b.dst),
    .MemOutput_W(out_b.mem)
  );

  function automatic bundle_t mk(logic rw, logic [3:0] mtr, logic [31:0] pc, logic [31:0] pc8,
                                 logic [31:0] alu, logic [31:0] mem, logic [4:0] dst);
    bundle_t b;
    b.rw = rw; b.mtr = mtr; b.pc = pc; b.pc8 = pc8; b.alu = alu; b.mem = mem; b.dst = dst;
    return b;
  endfunction

  // Reference model: what W must hold after an edge that saw (rst, b).
  function automatic bundle_t model(logic rst, bundle_t b);
    bundle_t e;
    if (rst) return '0;
    e = b;
    if (SQUASH && b.dst == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input bundle_t act, input bundle_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rw=%b mtr=%h pc=%h pc8=%h alu=%h mem=%h dst=%0d, want rw=%b mtr=%h pc=%h pc8=%h alu=%h mem=%h dst=%0d",
               name, act.rw, act.mtr, act.pc, act.pc8, act.alu, act.mem, act.dst,
               exp.rw, exp.mtr, exp.pc, exp.pc8, exp.alu, exp.mem, exp.dst);
    end
  endtask

  task automatic apply(input logic rst, input bundle_t b, input bundle_t exp, input string name);
    @(negedge clk);
    reset = rst;
    in_b  = b;
    @(posedge clk);
    #1;
    check(name, out_b, exp);
  endtask

  bundle_t base, ones, zeros, dz, held, r;
  vec_t    vecs[14];
  logic    rr;

  initial begin
    reset = 1'b1;
    in_b  = '0;

    base  = mk(1'b1, 4'hF, 32'h3000, 32'h3008, 32'hDEADBEEF, 32'h12345678, 5'd31);
    ones  = mk(1'b1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F);
    zeros = '0;
    dz    = mk(1'b1, 4'h3, 32'h4000, 32'h4008, 32'h00000055, 32'h000000AA, 5'd0);

    vecs[0]  = '{1'b1, base, '0, "reset_edge1"};
    vecs[1]  = '{1'b1, base, '0, "reset_edge2"};
    vecs[2]  = '{1'b0, base, base, "single_capture"};
    vecs[3]  = '{1'b0, mk(1'b1, 4'h1, 32'h3000, 32'h3008, 32'h11, 32'h21, 5'd1),
                       mk(1'b1, 4'h1, 32'h3000, 32'h3008, 32'h11, 32'h21, 5'd1), "stream_3000"};
    vecs[4]  = '{1'b0, mk(1'b0, 4'h2, 32'h3004, 32'h300C, 32'h12, 32'h22, 5'd2),
                       mk(1'b0, 4'h2, 32'h3004, 32'h300C, 32'h12, 32'h22, 5'd2), "stream_3004"};
    vecs[5]  = '{1'b0, mk(1'b1, 4'h4, 32'h3008, 32'h3010, 32'h13, 32'h23, 5'd3),
                       mk(1'b1, 4'h4, 32'h3008, 32'h3010, 32'h13, 32'h23, 5'd3), "stream_3008"};
    vecs[6]  = '{1'b1, base, '0, "reset_midstream"};
    vecs[7]  = '{1'b0, mk(1'b1, 4'h8, 32'h500C, 32'h5014, 32'hCAFEF00D, 32'h0BADBEEF, 5'd17),
                       mk(1'b1, 4'h8, 32'h500C, 32'h5014, 32'hCAFEF00D, 32'h0BADBEEF, 5'd17), "after_reset"};
    vecs[8]  = '{1'b0, ones, ones, "all_ones"};
    vecs[9]  = '{1'b0, zeros, zeros, "all_zeros"};
    vecs[10] = '{1'b0, ones, ones, "ones_again"};
    vecs[11] = '{1'b0, dz, mk(!SQUASH, 4'h3, 32'h4000, 32'h4008, 32'h00000055, 32'h000000AA, 5'd0),
                 "dst_zero"};
    vecs[12] = '{1'b0, mk(1'b0, 4'hA, 32'h4004, 32'h400C, 32'h1, 32'h2, 5'd0),
                       mk(1'b0, 4'hA, 32'h4004, 32'h400C, 32'h1, 32'h2, 5'd0), "dst_zero_nowrite"};
    vecs[13] = '{1'b0, mk(1'b1, 4'h5, 32'h4008, 32'h4010, 32'h7, 32'h9, 5'd1),
                       mk(1'b1, 4'h5, 32'h4008, 32'h4010, 32'h7, 32'h9, 5'd1), "dst_one"};

    foreach (vecs[i]) apply(vecs[i].rst, vecs[i].in, vecs[i].exp, vecs[i].name);

    // Inputs changing between edges must not reach the outputs.
    apply(1'b0, base, base, "hold_capture");
    @(negedge clk);
    in_b = ones;
    #2;
    check("midcycle_hold", out_b, base);
    reset = 1'b1;
    #2;
    check("midcycle_reset_ignored", out_b, base);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midcycle_next_edge", out_b, ones);

    // Random stream with occasional reset pulses.
    for (int k = 0; k < 300; k++) begin
      r.rw  = 1'($urandom);
      r.mtr = 4'($urandom);
      r.pc  = $urandom;
      r.pc8 = $urandom;
      r.alu = $urandom;
      r.mem = $urandom;
      r.dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rr    = ($urandom_range(0, 15) == 0);
      apply(rr, r, model(rr, r), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
